// File: rtl/traffic_intersection_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : traffic_intersection_ctrl
// Description : Two-direction (NS/EW) intersection controller with a tick
//               prescaler, a per-phase countdown, a fixed phase ring with
//               all-red clearance, pedestrian early-green termination and a
//               flash (maintenance) mode with blinking yellow.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_intersection_ctrl #(
    parameter int TICK_DIV    = 100000000,
    parameter int GREEN_TIME  = 9,
    parameter int MIN_GREEN   = 3,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 1,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flash_req,
    input  logic [1:0]       ped_req,
    output logic [2:0]       ns_lights,
    output logic [2:0]       ew_lights,
    output logic [1:0]       walk,
    output logic [CNT_W-1:0] count,
    output logic [2:0]       phase,
    output logic             tick
);

    localparam int TCNT_W = $clog2(TICK_DIV);

    localparam logic [TCNT_W-1:0] TCNT_LAST  = TCNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  GREEN_CNT  = CNT_W'(GREEN_TIME);
    localparam logic [CNT_W-1:0]  YELLOW_CNT = CNT_W'(YELLOW_TIME);
    localparam logic [CNT_W-1:0]  ALLRED_CNT = CNT_W'(ALLRED_TIME);
    localparam logic [CNT_W-1:0]  ONE        = CNT_W'(1);
    // Elapsed green (GREEN_TIME - count + 1) reaches MIN_GREEN exactly when
    // count has fallen to this value or below.
    localparam logic [CNT_W-1:0]  CUT_LIMIT  = CNT_W'(GREEN_TIME + 1 - MIN_GREEN);

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        NS_G = 3'd1,
        NS_Y = 3'd2,
        AR1  = 3'd3,
        EW_G = 3'd4,
        EW_Y = 3'd5,
        AR2  = 3'd6
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_n;
    logic [TCNT_W-1:0]  tcnt;
    logic [TCNT_W-1:0]  tcnt_n;
    logic               blink;
    logic               blink_n;
    logic [1:0]         ped_pending;
    logic [1:0]         ped_n;

    assign tick  = (tcnt == TCNT_LAST);
    assign phase = state;
    assign count = cnt;

    // State register: phase, countdown, prescaler, blink and pending requests
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            tcnt        <= '0;
            blink       <= 1'b0;
            ped_pending <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            tcnt        <= tcnt_n;
            blink       <= blink_n;
            ped_pending <= ped_n;
        end
    end

    // Next-state logic: ring advance, countdown, early cut, flash and phase entry
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        blink_n = blink;
        ped_n   = ped_pending | ped_req;
        tcnt_n  = tick ? '0 : tcnt + TCNT_W'(1);

        case (state)
            IDLE: begin
                if (tick) begin
                    blink_n = ~blink;
                end
                if (start && !flash_req) begin
                    state_n = NS_G;
                end
            end
            NS_G: begin
                if (tick) begin
                    // flash overrides the minimum-green guard on the ped cut
                    if (flash_req || (cnt == ONE) || (ped_pending[1] && (cnt <= CUT_LIMIT))) begin
                        state_n = NS_Y;
                    end else begin
                        cnt_n = cnt - ONE;
                    end
                end
            end
            NS_Y: begin
                if (tick) begin
                    if (cnt == ONE) state_n = AR1;
                    else            cnt_n   = cnt - ONE;
                end
            end
            AR1: begin
                if (tick) begin
                    if (cnt == ONE) state_n = flash_req ? IDLE : EW_G;
                    else            cnt_n   = cnt - ONE;
                end
            end
            EW_G: begin
                if (tick) begin
                    if (flash_req || (cnt == ONE) || (ped_pending[0] && (cnt <= CUT_LIMIT))) begin
                        state_n = EW_Y;
                    end else begin
                        cnt_n = cnt - ONE;
                    end
                end
            end
            EW_Y: begin
                if (tick) begin
                    if (cnt == ONE) state_n = AR2;
                    else            cnt_n   = cnt - ONE;
                end
            end
            AR2: begin
                if (tick) begin
                    if (cnt == ONE) state_n = flash_req ? IDLE : NS_G;
                    else            cnt_n   = cnt - ONE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Phase entry: restart the prescaler and load the new duration.
        // Entering a green serves (clears) that direction's ped request,
        // overriding a request arriving in the same cycle.
        if (state_n != state) begin
            tcnt_n = '0;
            case (state_n)
                IDLE: begin
                    cnt_n   = '0;
                    blink_n = 1'b0;
                end
                NS_G: begin
                    cnt_n    = GREEN_CNT;
                    ped_n[0] = 1'b0;
                end
                EW_G: begin
                    cnt_n    = GREEN_CNT;
                    ped_n[1] = 1'b0;
                end
                NS_Y, EW_Y: begin
                    cnt_n = YELLOW_CNT;
                end
                default: begin
                    cnt_n = ALLRED_CNT;
                end
            endcase
        end
    end

    // Output decode: lamps and walk signals straight from the registered phase
    always_comb begin
        ns_lights = RED;
        ew_lights = RED;
        walk      = 2'b00;
        case (state)
            IDLE: begin
                ns_lights = {1'b0, blink, 1'b0};
                ew_lights = {1'b0, blink, 1'b0};
            end
            NS_G: begin
                ns_lights = GREEN;
                walk      = 2'b01;
            end
            NS_Y: begin
                ns_lights = YELLOW;
            end
            EW_G: begin
                ew_lights = GREEN;
                walk      = 2'b10;
            end
            EW_Y: begin
                ew_lights = YELLOW;
            end
            default: begin
                ns_lights = RED;
                ew_lights = RED;
            end
        endcase
    end

endmodule
`default_nettype wire
